// File: rtl/uart_rx_ctrl_gen.sv
// uart_rx_ctrl_gen: parametrised UART receiver (majority sampling, parity, 1/2 stop bits, error pulses).
// Optional break detection is built when UART_RX_BREAK_DET_EN is defined.
module uart_rx_ctrl_gen #(
  parameter int DATA_W  = 8,
  parameter int PRESC_W = 6
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic               PAR_EN,
  input  logic               PAR_TYP,
  input  logic               STP2_EN,
  output logic [DATA_W-1:0]  P_DATA,
  output logic               data_valid,
  output logic               par_err,
  output logic               stp_err,
  output logic               break_det,
  output logic               busy
);
  localparam int BW = $clog2(DATA_W + 4);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
  state_t state, nxt;
  logic [PRESC_W-1:0] p, ec, h, dec_e;
  logic [BW-1:0] bc;
  logic [2:0] s;
  logic [DATA_W-1:0] sh;
  logic par_en, par_typ, stp2, par_bad, stp_bad;
  logic wrap, at_dec, s2, maj, last, done, fin_par, fin_stp, good, brk;
  assign h = p >> 1;
  // With P=4 there is no edge P/2+2, so decide on the last edge using the live third sample.
  assign dec_e = (p == PRESC_W'(4)) ? PRESC_W'(3) : h + PRESC_W'(2);
  assign wrap = ec == p - PRESC_W'(1);
  assign at_dec = ec == dec_e;
  assign s2 = (ec == h + PRESC_W'(1)) ? RX_IN : s[2];
  assign maj = (s[0] & s[1]) | (s[0] & s2) | (s[1] & s2);
  assign last = !stp2 || bc == BW'(DATA_W + 2) + BW'(par_en);
  assign done = state == STOP && at_dec && last;
  assign fin_stp = stp_bad | !maj;
  assign fin_par = par_en & par_bad;
  assign good = done & !fin_stp & !fin_par;
`ifdef UART_RX_BREAK_DET_EN
  logic par_bit, stp_one;
  assign brk = sh == '0 && !(par_en && par_bit) && !(stp_one || maj);
`else
  assign brk = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (RST) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = !RX_IN ? START : IDLE;
      START:   nxt = (at_dec && maj) ? IDLE : wrap ? DATA : START;
      DATA:    nxt = (wrap && bc == BW'(DATA_W)) ? (par_en ? PARITY : STOP) : DATA;
      PARITY:  nxt = wrap ? STOP : PARITY;
      STOP:    nxt = done ? (brk ? BRK : IDLE) : STOP;
`ifdef UART_RX_BREAK_DET_EN
      BRK:     nxt = (at_dec && maj) ? IDLE : BRK;
`endif
      default: nxt = IDLE;
    endcase
  end
  always_comb busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (RST) begin
      ec <= '0;
      bc <= '0;
      s <= '0;
      sh <= '0;
      p <= PRESC_W'(4);
      par_en <= 1'b0;
      par_typ <= 1'b0;
      stp2 <= 1'b0;
      par_bad <= 1'b0;
      stp_bad <= 1'b0;
      P_DATA <= '0;
      data_valid <= 1'b0;
      par_err <= 1'b0;
      stp_err <= 1'b0;
      break_det <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      par_bit <= 1'b0;
      stp_one <= 1'b0;
`endif
    end else begin
      data_valid <= good;
      par_err <= done & fin_par & !brk;
      stp_err <= done & fin_stp & !brk;
      break_det <= done & brk;
      if (good) P_DATA <= sh;
      if (ec == h - PRESC_W'(1)) s[0] <= RX_IN;
      if (ec == h) s[1] <= RX_IN;
      if (ec == h + PRESC_W'(1)) s[2] <= RX_IN;
      if (state == IDLE) begin
        ec <= PRESC_W'(!RX_IN);
        bc <= '0;
        if (!RX_IN) begin
          p <= (Prescale < PRESC_W'(4)) ? PRESC_W'(4) : Prescale;
          par_en <= PAR_EN;
          par_typ <= PAR_TYP;
          stp2 <= STP2_EN;
          par_bad <= 1'b0;
          stp_bad <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
          par_bit <= 1'b0;
          stp_one <= 1'b0;
`endif
        end
      end else if (nxt == IDLE) begin
        ec <= '0;
        bc <= '0;
      end else begin
        ec <= wrap ? '0 : ec + PRESC_W'(1);
        if (wrap && state != BRK) bc <= bc + BW'(1);
      end
      // Right shift with MSB insertion leaves the first-received bit in the LSB.
      if (at_dec && state == DATA) sh <= {maj, sh[DATA_W-1:1]};
      if (at_dec && state == PARITY) par_bad <= maj != (^sh ^ par_typ);
      if (at_dec && state == STOP) stp_bad <= stp_bad | !maj;
`ifdef UART_RX_BREAK_DET_EN
      if (at_dec && state == PARITY) par_bit <= maj;
      if (at_dec && state == STOP) stp_one <= stp_one | maj;
`endif
    end
  end
endmodule

// File: tb/tb_uart_rx_ctrl_gen.sv
// tb_uart_rx_ctrl_gen: directed and random UART frames checked against a frame-level reference model.
module tb_uart_rx_ctrl_gen;
  logic clk = 1'b0;
  logic RST, RX_IN, PAR_EN, PAR_TYP, STP2_EN;
  logic [5:0] Prescale;
  logic [7:0] P_DATA;
  logic data_valid, par_err, stp_err, break_det, busy;
  int total = 0, bad = 0;
  int n_dv = 0, n_pe = 0, n_se = 0, n_bk = 0, n_long = 0;
  logic pdv = 1'b0, ppe = 1'b0, pse = 1'b0;
  logic [7:0] exp_data;
  always #5 clk = ~clk;
  uart_rx_ctrl_gen dut (
    .clk(clk), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .STP2_EN(STP2_EN), .P_DATA(P_DATA), .data_valid(data_valid),
    .par_err(par_err), .stp_err(stp_err), .break_det(break_det), .busy(busy)
  );
  always @(posedge clk) begin
    #1;
    n_dv += int'(data_valid);
    n_pe += int'(par_err);
    n_se += int'(stp_err);
    n_bk += int'(break_det);
    if ((data_valid && pdv) || (par_err && ppe) || (stp_err && pse)) n_long++;
    pdv = data_valid;
    ppe = par_err;
    pse = stp_err;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic send_bit(input logic b, input int p);
    RX_IN = b;
    repeat (p) @(negedge clk);
  endtask
  task automatic frame(input logic [7:0] d, input int presc, input logic pe, input logic pt,
                       input logic s2, input logic fp, input logic [1:0] sbad, input int gap);
    int p, g, b_dv, b_pe, b_se, b_bk;
    logic perr, serr;
    p = presc < 4 ? 4 : presc;
    perr = pe && fp;
    serr = sbad[0] || (s2 && sbad[1]);
    g = (serr && gap < 2 * p) ? 2 * p : gap;
    b_dv = n_dv; b_pe = n_pe; b_se = n_se; b_bk = n_bk;
    Prescale = 6'(presc);
    PAR_EN = pe;
    PAR_TYP = pt;
    STP2_EN = s2;
    send_bit(1'b0, p);
    Prescale = 6'($urandom);
    PAR_EN = 1'($urandom);
    PAR_TYP = 1'($urandom);
    STP2_EN = 1'($urandom);
    for (int i = 0; i < 8; i++) send_bit(d[i], p);
    if (pe) send_bit((^d) ^ pt ^ fp, p);
    send_bit(!sbad[0], p);
    if (s2) send_bit(!sbad[1], p);
    RX_IN = 1'b1;
    repeat (g) @(negedge clk);
    if (!perr && !serr) exp_data = d;
    chk("data_valid_cnt", n_dv - b_dv, (!perr && !serr) ? 1 : 0);
    chk("par_err_cnt", n_pe - b_pe, perr ? 1 : 0);
    chk("stp_err_cnt", n_se - b_se, serr ? 1 : 0);
    chk("break_cnt", n_bk - b_bk, 0);
    chk("p_data", P_DATA, exp_data);
    if (!serr || g >= 2 * p) chk("busy_idle", busy, 0);
  endtask
  initial begin
    int b_dv, b_pe, b_se;
    logic [7:0] d;
    RST = 1'b1; RX_IN = 1'b1; Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0; STP2_EN = 1'b0;
    exp_data = 8'h00;
    repeat (3) @(negedge clk);
    RST = 1'b0;
    chk("rst_p_data", P_DATA, 0);
    chk("rst_pulses", {data_valid, par_err, stp_err, break_det}, 0);
    chk("rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 16);
    b_dv = n_dv; b_pe = n_pe; b_se = n_se;
    Prescale = 6'd8;
    RX_IN = 1'b0;
    repeat (3) @(negedge clk);
    chk("glitch_busy", busy, 1);
    RX_IN = 1'b1;
    repeat (8) @(negedge clk);
    chk("glitch_idle", busy, 0);
    chk("glitch_pulses", (n_dv - b_dv) + (n_pe - b_pe) + (n_se - b_se), 0);
    chk("glitch_p_data", P_DATA, 8'hA5);
    frame(8'h3C, 16, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 32);
    frame(8'h69, 16, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 48);
    frame(8'h00, 32, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 0);
    frame(8'hFF, 32, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 0);
    d = 8'hC3;
    Prescale = 6'd8; PAR_EN = 1'b0; STP2_EN = 1'b0;
    send_bit(1'b0, 8);
    for (int i = 0; i < 3; i++) send_bit(d[i], 8);
    RX_IN = d[3];
    repeat (4) @(negedge clk);
    b_dv = n_dv; b_pe = n_pe; b_se = n_se;
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
    RX_IN = 1'b1;
    exp_data = 8'h00;
    chk("midrst_p_data", P_DATA, 0);
    chk("midrst_busy", busy, 0);
    repeat (40) @(negedge clk);
    chk("midrst_pulses", (n_dv - b_dv) + (n_pe - b_pe) + (n_se - b_se), 0);
    frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8);
    for (int k = 0; k < 40; k++) begin
      frame(8'($urandom), int'($urandom_range(0, 24)), 1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom % 4) == 0, ($urandom % 4) == 0 ? 2'($urandom_range(1, 3)) : 2'b00,
            ($urandom % 3) == 0 ? 0 : int'($urandom_range(1, 30)));
    end
    chk("pulse_width", n_long, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
